// File: rtl/stream_reg_pkg.sv
// Shared types and constants for the stream register blocks.
package stream_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } spill_state_e;

  localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/stream_spill_slot.sv
// Single payload storage register with load enable, reset to zero.
module stream_spill_slot #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  T     data_i,
  output T     data_o
);

  T data_q;
  T data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) data_d = data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) data_q <= '0;
    else         data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/stream_spill_register.sv
// Two-entry ready/valid spill register; all outputs come from flops.
// Define STREAM_SPILL_STATS_EN to add the saturating stall counter port stall_cnt_o.
module stream_spill_register
  import stream_reg_pkg::*;
#(
  parameter type  T      = logic,
  parameter logic BYPASS = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
`ifdef STREAM_SPILL_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
`endif
);

  logic stall_cond;

  if (BYPASS) begin : g_bypass
    assign ready_o    = ready_i;
    assign valid_o    = valid_i;
    assign data_o     = data_i;
    assign stall_cond = valid_i & ~ready_i;
  end else begin : g_spill
    spill_state_e state_q, state_d;
    logic         head_q, head_d;
    logic         valid_q, valid_d;
    logic         ready_q, ready_d;
    logic         in_xfer, out_xfer, wr_sel;
    logic [1:0]   load;
    T             slot_data [2];

    assign in_xfer  = valid_i & ready_q;
    assign out_xfer = valid_q & ready_i;
    // An empty register writes the head slot; otherwise the free slot is the tail.
    assign wr_sel   = (state_q == EMPTY) ? head_q : ~head_q;

    always_comb begin
      state_d = state_q;
      head_d  = head_q;
      load    = 2'b00;
      if (in_xfer) load[wr_sel] = 1'b1;
      unique case (state_q)
        EMPTY: if (in_xfer) state_d = HALF;
        HALF: begin
          if (in_xfer && !out_xfer) state_d = FULL;
          else if (!in_xfer && out_xfer) state_d = EMPTY;
          if (out_xfer) head_d = ~head_q;
        end
        FULL: if (out_xfer) begin
          state_d = HALF;
          head_d  = ~head_q;
        end
        default: state_d = EMPTY;
      endcase
      if (clr_i) state_d = EMPTY;
      valid_d = (state_d != EMPTY);
      ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= EMPTY;
        head_q  <= 1'b0;
        valid_q <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        state_q <= state_d;
        head_q  <= head_d;
        valid_q <= valid_d;
        ready_q <= ready_d;
      end
    end

    for (genvar s = 0; s < 2; s++) begin : g_slot
      stream_spill_slot #(.T(T)) u_slot (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (load[s]),
        .data_i (data_i),
        .data_o (slot_data[s])
      );
    end

    assign valid_o    = valid_q;
    assign ready_o    = ready_q;
    assign data_o     = head_q ? slot_data[1] : slot_data[0];
    assign stall_cond = valid_q & ~ready_i;
  end

`ifdef STREAM_SPILL_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_i) stall_cnt_d = '0;
    else if (stall_cond && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_stall;
  assign unused_stall = stall_cond;
`endif

endmodule

// File: tb/tb_stream_spill_register.sv
// Directed bench for stream_spill_register with an occupancy model and FIFO scoreboard.
module tb_stream_spill_register;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       clr_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] data_i = 8'h00;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
`ifdef STREAM_SPILL_STATS_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] stall_exp = 32'd0;
`endif

  int         checks = 0;
  int         failures = 0;
  int         occ = 0;
  logic [7:0] sb_q[$];

  stream_spill_register #(.T(logic [7:0]), .BYPASS(1'b0)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o)
`ifdef STREAM_SPILL_STATS_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock: model the handshake at the edge, then check flop outputs.
  task automatic applyStimulus();
    logic       in_x, out_x;
    logic [7:0] exp_d;
    if (clr_i) begin
      sb_q.delete();
      occ = 0;
`ifdef STREAM_SPILL_STATS_EN
      stall_exp = 32'd0;
`endif
    end else begin
`ifdef STREAM_SPILL_STATS_EN
      if (occ > 0 && !ready_i && stall_exp != 32'hFFFF_FFFF) stall_exp++;
`endif
      out_x = (occ > 0) && ready_i;
      in_x  = valid_i && (occ < 2);
      if (out_x) begin
        if (sb_q.size() == 0) checkOutput("scoreboard_empty", 32'd1, 32'd0);
        else begin
          exp_d = sb_q.pop_front();
          checkOutput("data_o", {24'd0, data_o}, {24'd0, exp_d});
        end
      end
      if (in_x) sb_q.push_back(data_i);
      occ = occ + int'(in_x) - int'(out_x);
    end
    @(posedge clk_i);
    #1;
    checkOutput("valid_o", {31'd0, valid_o}, {31'd0, occ > 0});
    checkOutput("ready_o", {31'd0, ready_o}, {31'd0, occ < 2});
`ifdef STREAM_SPILL_STATS_EN
    checkOutput("stall_cnt_o", stall_cnt_o, stall_exp);
`endif
  endtask

  initial begin
    #12;
    checkOutput("rst_valid_o", {31'd0, valid_o}, 32'd0);
    checkOutput("rst_ready_o", {31'd0, ready_o}, 32'd1);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("rst_data_o", {24'd0, data_o}, 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus();
    checkOutput("idle_data_o", {24'd0, data_o}, 32'd0);

    // Streaming 1..8 at full rate
    ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      valid_i = 1'b1;
      data_i  = 8'(i);
      applyStimulus();
      checkOutput("stream_latency", {24'd0, data_o}, i);
    end
    valid_i = 1'b0;
    for (int i = 0; i < 2; i++) applyStimulus();

    // Backpressure: A and B fill the register, C is held off
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i = 8'h11; applyStimulus();
    data_i = 8'h22; applyStimulus();
    checkOutput("bp_full", {31'd0, ready_o}, 32'd0);
    data_i = 8'h33; applyStimulus(); applyStimulus();
    ready_i = 1'b1;
    applyStimulus(); applyStimulus();
    valid_i = 1'b0;
    applyStimulus(); applyStimulus();
    checkOutput("bp_drained", sb_q.size(), 32'd0);

    // Path cut: ready_i toggled while FULL reaches ready_o only at the edge
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i = 8'hA1; applyStimulus();
    data_i = 8'hA2; applyStimulus();
    valid_i = 1'b0;
    ready_i = 1'b1;
    #2;
    checkOutput("cut_ready_o", {31'd0, ready_o}, 32'd0);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    valid_i = 1'b1;
    data_i = 8'hB5;
    #2;
    checkOutput("cut_valid_o", {31'd0, valid_o}, 32'd0);
    applyStimulus();
    valid_i = 1'b0;
    applyStimulus();

    // Clear while FULL, with simultaneous input and output requests
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i = 8'hC1; applyStimulus();
    data_i = 8'hC2; applyStimulus();
    clr_i = 1'b1;
    ready_i = 1'b1;
    data_i = 8'hC3;
    applyStimulus();
    clr_i = 1'b0;
    valid_i = 1'b0;
    applyStimulus();
    checkOutput("clr_no_emit", {31'd0, valid_o}, 32'd0);

    // Asynchronous reset mid-operation
    valid_i = 1'b1;
    data_i = 8'hD1;
    applyStimulus();
    valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    checkOutput("midrst_valid_o", {31'd0, valid_o}, 32'd0);
    checkOutput("midrst_data_o", {24'd0, data_o}, 32'd0);
    sb_q.delete();
    occ = 0;
`ifdef STREAM_SPILL_STATS_EN
    stall_exp = 32'd0;
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    applyStimulus();
    data_i = 8'hE7;
    valid_i = 1'b1;
    ready_i = 1'b1;
    applyStimulus();
    valid_i = 1'b0;
    applyStimulus();

`ifdef STREAM_SPILL_STATS_EN
    // Stall counter: 10 stalled cycles, clear, then saturation
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i = 8'hF0;
    applyStimulus();
    valid_i = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus();
    checkOutput("stall_ten", stall_cnt_o, 32'd10);
    clr_i = 1'b1;
    applyStimulus();
    clr_i = 1'b0;
    checkOutput("stall_clr", stall_cnt_o, 32'd0);
    valid_i = 1'b1;
    applyStimulus();
    valid_i = 1'b0;
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk_i);
    #1;
    release dut.stall_cnt_q;
    stall_exp = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("stall_sat", stall_cnt_o, 32'hFFFF_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_spill_register.md
Name: stream_spill_register

Overview:
- Two-entry ready/valid pipeline register that cuts every combinational path between its input and output ports.
- Covers valid, data and ready; it complements the fall-through style used where a default-ready input is wanted.
- Placed at stream boundaries with long ready/valid paths, e.g. between AXI channel slices and the neuropipe compute stages.
- Sustains one transfer per cycle at a fixed forward latency of one cycle.

Parameters:
- T, logic, payload type; width derived with $bits(T).
- BYPASS, 1'b0, 1 = pure wire-through (ready_o=ready_i, valid_o=valid_i, data_o=data_i), no state; 0 = registered spill behaviour.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- clr_i  input  1  synchronous clear, drops stored entries
- valid_i  input  1  upstream valid
- ready_o  output  1  upstream ready
- data_i  input  $bits(T)  upstream payload
- valid_o  output  1  downstream valid
- ready_i  input  1  downstream ready
- data_o  output  $bits(T)  downstream payload

Behaviour:
- Clocking: one clock, clk_i. Reset is asynchronous, active-low on rst_ni. All state is reset to EMPTY.
- Reset values: valid_o=0, ready_o=1, data_o='0.
- Path cutting: valid_o, ready_o and data_o are driven only from flops (state and slot registers). No combinational path from any input to any output when BYPASS=0.
- Handshakes: input transfer when valid_i & ready_o; output transfer when valid_o & ready_i.
- Once valid_o=1, valid_o and data_o stay stable until the output transfer.
- valid_i is sampled only when ready_o=1. Data presented while ready_o=0 is ignored and never stored.
- State EMPTY: valid_o=0, ready_o=1.
  - input transfer -> HALF, entry stored as head.
- State HALF: valid_o=1, ready_o=1, data_o=head.
  - input and output transfer -> HALF, new entry becomes head.
  - input only -> FULL, new entry stored as tail.
  - output only -> EMPTY.
  - neither -> HALF.
- State FULL: valid_o=1, ready_o=0, data_o=head.
  - output transfer -> HALF, tail becomes head.
  - otherwise hold.
- Ordering: strict FIFO order, no loss, no duplication.
- Slot arrangement: two data slots plus a one-bit head pointer, so no data moves between slots. An implementation that shifts the tail into the head is also acceptable provided outputs remain flop-driven.
- Latency and throughput: entry accepted in cycle n is visible on data_o in cycle n+1. Back-to-back transfers give 1 transfer/cycle steady state.
- clr_i:
  - forces EMPTY next cycle;
  - takes priority over any simultaneous input or output transfer in the same cycle;
  - leaves data registers don't-care;
  - clearing while FULL discards both entries.
- Reset mid-operation: immediate return to EMPTY, stored entries lost.
- BYPASS=1: no flops; clr_i is ignored.

Optional Feature:
- Macro: STREAM_SPILL_STATS_EN.
- With the macro defined:
  - adds output port stall_cnt_o, 32 bits;
  - counts cycles with valid_o & ~ready_i;
  - saturates at 32'hFFFF_FFFF;
  - reset to 0 and cleared to 0 by clr_i.
- Without the macro: port and counter are absent.
- Under BYPASS=1 the counter still counts valid_i & ~ready_i.

Decomposition:
- Package stream_reg_pkg:
  - spill_state_e enum {EMPTY, HALF, FULL}, 2 bits;
  - localparam STALL_CNT_W=32.
- Sub-module stream_spill_slot:
  - one data register with load enable;
  - instantiated twice, selected by the head pointer.
- Top-level holds the state machine, head pointer, and optional counter.

Test Plan:
- Reset: after rst_ni deasserts, valid_o=0, ready_o=1, data_o=0; idle for 5 cycles -> no change.
- Streaming: valid_i=1 and ready_i=1 with data 1..8 on cycles 0..7 -> valid_o=1 on cycles 1..8 with data_o=1..8; ready_o stays 1.
- Backpressure: ready_i=0 while sending A=8'h11 and B=8'h22:
  - ready_o falls to 0 the cycle after B is accepted;
  - C=8'h33 is held off;
  - ready_i=1 -> outputs 11, 22, 33 in order, no loss.
- Path-cut check:
  - toggle ready_i in FULL -> ready_o changes only on the following clock edge;
  - toggle valid_i in EMPTY -> valid_o changes only on the next edge.
- Clear: in FULL assert clr_i together with valid_i and ready_i -> next cycle EMPTY, valid_o=0, ready_o=1, no entry emitted.
- Stats (STREAM_SPILL_STATS_EN): hold valid_o=1 with ready_i=0 for 10 cycles -> stall_cnt_o=10; clr_i -> 0; force the count to 32'hFFFF_FFFF -> it stays saturated.
